rx_resp_arbiter: RTL and testbench

RX_RESP_ARBITER -- requirements
Module: rx_resp_arbiter

---
 rtl/rx_resp_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_rx_resp_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_resp_arbiter.sv
// Response arbiter: per-channel tag FIFOs pair op_ids with completions, one hold
// slot per channel, one output register. Define RX_RR_ARB_EN for round-robin, else fixed priority.
module rx_resp_arbiter #(
  parameter int NUM_SW_INST = 5,
  parameter int W_WIDTH     = 8,
  parameter int ID_WIDTH    = 8,
  parameter int FIFO_DEPTH  = 4,
  localparam int CH_W       = (NUM_SW_INST > 1) ? $clog2(NUM_SW_INST) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_SW_INST-1:0]         sel_en,
  input  logic [ID_WIDTH-1:0]            op_id,
  input  logic [NUM_SW_INST-1:0]         ack,
  input  logic [NUM_SW_INST*W_WIDTH-1:0] rd_data,
  input  logic                           out_ready,
  output logic [NUM_SW_INST-1:0]         sw_busy,
  output logic                           out_valid,
  output logic [W_WIDTH-1:0]             rd_data_out,
  output logic [ID_WIDTH-1:0]            op_id_out,
  output logic [CH_W-1:0]                ch_out,
  output logic [NUM_SW_INST-1:0]         err_ovf,
  output logic [NUM_SW_INST-1:0]         err_unexp
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_WIDTH-1:0]    r_mem       [NUM_SW_INST][FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr    [NUM_SW_INST];
  logic [PTR_W-1:0]       r_rd_ptr    [NUM_SW_INST];
  logic [CNT_W-1:0]       r_cnt       [NUM_SW_INST];
  logic [NUM_SW_INST-1:0] r_busy;
  logic [NUM_SW_INST-1:0] r_err_ovf;
  logic [NUM_SW_INST-1:0] r_err_unexp;
  logic [NUM_SW_INST-1:0] r_hold_vld;
  logic [ID_WIDTH-1:0]    r_hold_id   [NUM_SW_INST];
  logic [W_WIDTH-1:0]     r_hold_data [NUM_SW_INST];
  logic                   r_out_valid;
  logic [W_WIDTH-1:0]     r_out_data;
  logic [ID_WIDTH-1:0]    r_out_id;
  logic [CH_W-1:0]        r_out_ch;

  logic [NUM_SW_INST-1:0] w_full;
  logic [NUM_SW_INST-1:0] w_empty;
  logic [NUM_SW_INST-1:0] w_pop;
  logic [NUM_SW_INST-1:0] w_push;
  logic [NUM_SW_INST-1:0] w_drain;
  logic [NUM_SW_INST-1:0] w_hold_load;
  logic [NUM_SW_INST-1:0] w_err_ovf;
  logic [NUM_SW_INST-1:0] w_err_unexp;
  logic [CNT_W-1:0]       w_cnt_nxt   [NUM_SW_INST];
  logic [ID_WIDTH-1:0]    w_head      [NUM_SW_INST];
  logic                   w_out_load;
  logic                   w_grant_vld;
  logic [CH_W-1:0]        w_grant_idx;

  // Output handshake: a response transfers on a cycle where out_valid && out_ready;
  // the output register only reloads when it is empty or transferring, so it holds
  // steady under backpressure.
  assign w_out_load = ~r_out_valid | out_ready;

`ifdef RX_RR_ARB_EN
  logic [CH_W-1:0] r_rr_ptr;

  // Search starts at r_rr_ptr; the smallest offset with a valid hold wins.
  always_comb begin
    logic [CH_W:0] v_sum;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    v_sum       = '0;
    for (int k = NUM_SW_INST - 1; k >= 0; k--) begin
      v_sum = {1'b0, r_rr_ptr} + (CH_W + 1)'(k);
      if (v_sum >= (CH_W + 1)'(NUM_SW_INST)) v_sum = v_sum - (CH_W + 1)'(NUM_SW_INST);
      if (r_hold_vld[v_sum[CH_W-1:0]]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = v_sum[CH_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_out_load && w_grant_vld) begin
      if (w_grant_idx == CH_W'(NUM_SW_INST - 1)) r_rr_ptr <= '0;
      else                                       r_rr_ptr <= w_grant_idx + CH_W'(1);
    end
  end
`else
  // Fixed priority: descending scan so the lowest valid index is the last write.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int i = NUM_SW_INST - 1; i >= 0; i--) begin
      if (r_hold_vld[i]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = CH_W'(i);
      end
    end
  end
`endif

  always_comb begin
    for (int i = 0; i < NUM_SW_INST; i++) begin
      w_full[i]      = (r_cnt[i] == CNT_W'(FIFO_DEPTH));
      w_empty[i]     = (r_cnt[i] == '0);
      w_head[i]      = r_mem[i][r_rd_ptr[i]];
      // A same-cycle push never makes an ack acceptable.
      w_pop[i]       = ack[i] & ~w_empty[i];
      w_push[i]      = sel_en[i] & (~w_full[i] | w_pop[i]);
      w_drain[i]     = w_out_load & w_grant_vld & (w_grant_idx == CH_W'(i));
      w_hold_load[i] = w_pop[i] & (~r_hold_vld[i] | w_drain[i]);
      w_err_ovf[i]   = sel_en[i] & w_full[i] & ~w_pop[i];
      w_err_unexp[i] = (ack[i] & w_empty[i]) | (w_pop[i] & r_hold_vld[i] & ~w_drain[i]);
      w_cnt_nxt[i]   = r_cnt[i] + CNT_W'(w_push[i]) - CNT_W'(w_pop[i]);
    end
  end

  // Tag storage carries no reset; only the pointers and count define its contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SW_INST; i++) begin
      if (w_push[i]) r_mem[i][r_wr_ptr[i]] <= op_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy      <= '0;
      r_err_ovf   <= '0;
      r_err_unexp <= '0;
      r_hold_vld  <= '0;
      for (int i = 0; i < NUM_SW_INST; i++) begin
        r_wr_ptr[i]    <= '0;
        r_rd_ptr[i]    <= '0;
        r_cnt[i]       <= '0;
        r_hold_id[i]   <= '0;
        r_hold_data[i] <= '0;
      end
    end else begin
      r_err_ovf   <= w_err_ovf;
      r_err_unexp <= w_err_unexp;
      for (int i = 0; i < NUM_SW_INST; i++) begin
        if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
        if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
        r_cnt[i]  <= w_cnt_nxt[i];
        r_busy[i] <= (w_cnt_nxt[i] != '0);
        if (w_hold_load[i]) begin
          r_hold_vld[i]  <= 1'b1;
          r_hold_id[i]   <= w_head[i];
          r_hold_data[i] <= rd_data[i*W_WIDTH +: W_WIDTH];
        end else if (w_drain[i]) begin
          r_hold_vld[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
      r_out_ch    <= '0;
    end else if (w_out_load) begin
      r_out_valid <= w_grant_vld;
      if (w_grant_vld) begin
        r_out_data <= r_hold_data[w_grant_idx];
        r_out_id   <= r_hold_id[w_grant_idx];
        r_out_ch   <= w_grant_idx;
      end
    end
  end

  assign sw_busy     = r_busy;
  assign err_ovf     = r_err_ovf;
  assign err_unexp   = r_err_unexp;
  assign out_valid   = r_out_valid;
  assign rd_data_out = r_out_data;
  assign op_id_out   = r_out_id;
  assign ch_out      = r_out_ch;

endmodule

// File: tb/tb_rx_resp_arbiter.sv
// Bench for rx_resp_arbiter: directed vector table, hand-written corner sequences,
// and random traffic checked cycle by cycle against a queue-based reference model.
module tb_rx_resp_arbiter;

  localparam int N  = 5;
  localparam int W  = 8;
  localparam int ID = 8;
  localparam int D  = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   sel_en;
  logic [ID-1:0]  op_id;
  logic [N-1:0]   ack;
  logic [N*W-1:0] rd_data;
  logic           out_ready;
  logic [N-1:0]   sw_busy;
  logic           out_valid;
  logic [W-1:0]   rd_data_out;
  logic [ID-1:0]  op_id_out;
  logic [2:0]     ch_out;
  logic [N-1:0]   err_ovf;
  logic [N-1:0]   err_unexp;

  rx_resp_arbiter #(.NUM_SW_INST(N), .W_WIDTH(W), .ID_WIDTH(ID), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .sel_en(sel_en), .op_id(op_id), .ack(ack),
    .rd_data(rd_data), .out_ready(out_ready), .sw_busy(sw_busy),
    .out_valid(out_valid), .rd_data_out(rd_data_out), .op_id_out(op_id_out),
    .ch_out(ch_out), .err_ovf(err_ovf), .err_unexp(err_unexp)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  int         m_cnt  [N];
  logic [7:0] m_tag  [N][D];
  bit         m_hv   [N];
  logic [7:0] m_hid  [N];
  logic [7:0] m_hdat [N];
  bit         m_ov;
  logic [7:0] m_oid, m_odat;
  int         m_och;
  int         m_ptr;
  logic [N-1:0] m_busy, m_eovf, m_eun;
  logic [15:0]  exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_hv[i] = 0; m_hid[i] = 0; m_hdat[i] = 0;
    end
    m_ov = 0; m_oid = 0; m_odat = 0; m_och = 0; m_ptr = 0;
    m_busy = 0; m_eovf = 0; m_eun = 0;
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int c;
`ifdef RX_RR_ARB_EN
      c = (m_ptr + k) % N;
`else
      c = k;
`endif
      if (m_hv[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [N-1:0] s, input logic [7:0] id,
                            input logic [N-1:0] a, input logic [N*W-1:0] d, input logic rdy);
    int g;
    g = pick();
    if (!m_ov || rdy) begin
      if (g >= 0) begin
        m_ov = 1; m_oid = m_hid[g]; m_odat = m_hdat[g]; m_och = g;
        m_hv[g] = 0; m_ptr = (g + 1) % N;
      end else begin
        m_ov = 0;
      end
    end
    for (int i = 0; i < N; i++) begin
      m_eovf[i] = 0;
      m_eun[i]  = 0;
      if (a[i]) begin
        if (m_cnt[i] == 0) begin
          m_eun[i] = 1;
        end else begin
          logic [7:0] head;
          head = m_tag[i][0];
          for (int k = 0; k < D - 1; k++) m_tag[i][k] = m_tag[i][k+1];
          m_cnt[i]--;
          if (!m_hv[i]) begin
            m_hv[i] = 1; m_hid[i] = head; m_hdat[i] = d[i*W +: W];
          end else begin
            m_eun[i] = 1;
          end
        end
      end
      if (s[i]) begin
        if (m_cnt[i] < D) begin
          m_tag[i][m_cnt[i]] = id;
          m_cnt[i]++;
        end else begin
          m_eovf[i] = 1;
        end
      end
      m_busy[i] = (m_cnt[i] > 0);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("busy", 32'(sw_busy), 32'(m_busy));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("err_ovf", 32'(err_ovf), 32'(m_eovf));
    check("err_unexp", 32'(err_unexp), 32'(m_eun));
    if (m_ov) begin
      check("op_id_out", 32'(op_id_out), 32'(m_oid));
      check("rd_data_out", 32'(rd_data_out), 32'(m_odat));
      check("ch_out", 32'(ch_out), 32'(m_och));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(sw_busy), 0);
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_data"}, 32'(rd_data_out), 0);
    check({tag, "_id"}, 32'(op_id_out), 0);
    check({tag, "_ch"}, 32'(ch_out), 0);
    check({tag, "_ovf"}, 32'(err_ovf), 0);
    check({tag, "_unexp"}, 32'(err_unexp), 0);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [N-1:0] s, input logic [7:0] id, input logic [N-1:0] a,
                      input logic [N*W-1:0] d, input logic rdy);
    sel_en = s; op_id = id; ack = a; rd_data = d; out_ready = rdy;
    model_step(s, id, a, d, rdy);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic idle(input logic rdy);
    step('0, 8'h00, '0, '0, rdy);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sel_en = '0; op_id = '0; ack = '0; rd_data = '0; out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] sel;
    logic [7:0]   id;
    logic [N-1:0] ack;
    logic [7:0]   dat;
    logic [N-1:0] e_busy;
    logic         e_ov;
    logic [7:0]   e_id;
    logic [7:0]   e_dat;
    logic [2:0]   e_ch;
    logic [N-1:0] e_eun;
  } vec_t;

  vec_t tbl[12];
  int   exp_ch[3];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // single path + unexpected-ack cases
    tbl[0]  = '{5'b00100, 8'h3A, 5'b00000, 8'h00, 5'b00100, 1'b0, 8'h00, 8'h00, 3'd0, 5'b00000};
    tbl[1]  = '{5'b00000, 8'h00, 5'b00000, 8'h00, 5'b00100, 1'b0, 8'h00, 8'h00, 3'd0, 5'b00000};
    tbl[2]  = '{5'b00000, 8'h00, 5'b00000, 8'h00, 5'b00100, 1'b0, 8'h00, 8'h00, 3'd0, 5'b00000};
    tbl[3]  = '{5'b00000, 8'h00, 5'b00100, 8'hC5, 5'b00000, 1'b0, 8'h00, 8'h00, 3'd0, 5'b00000};
    tbl[4]  = '{5'b00000, 8'h00, 5'b00000, 8'h00, 5'b00000, 1'b1, 8'h3A, 8'hC5, 3'd2, 5'b00000};
    tbl[5]  = '{5'b00000, 8'h00, 5'b00000, 8'h00, 5'b00000, 1'b0, 8'h00, 8'h00, 3'd0, 5'b00000};
    tbl[6]  = '{5'b00000, 8'h00, 5'b01000, 8'h11, 5'b00000, 1'b0, 8'h00, 8'h00, 3'd0, 5'b01000};
    tbl[7]  = '{5'b01000, 8'h55, 5'b01000, 8'h22, 5'b01000, 1'b0, 8'h00, 8'h00, 3'd0, 5'b01000};
    tbl[8]  = '{5'b00000, 8'h00, 5'b00000, 8'h00, 5'b01000, 1'b0, 8'h00, 8'h00, 3'd0, 5'b00000};
    tbl[9]  = '{5'b00000, 8'h00, 5'b01000, 8'h77, 5'b00000, 1'b0, 8'h00, 8'h00, 3'd0, 5'b00000};
    tbl[10] = '{5'b00000, 8'h00, 5'b00000, 8'h00, 5'b00000, 1'b1, 8'h55, 8'h77, 3'd3, 5'b00000};
    tbl[11] = '{5'b00000, 8'h00, 5'b00000, 8'h00, 5'b00000, 1'b0, 8'h00, 8'h00, 3'd0, 5'b00000};

    do_reset();

    for (int k = 0; k < 12; k++) begin
      step(tbl[k].sel, tbl[k].id, tbl[k].ack, {N{tbl[k].dat}}, 1'b1);
      check($sformatf("tbl%0d_busy", k), 32'(sw_busy), 32'(tbl[k].e_busy));
      check($sformatf("tbl%0d_valid", k), 32'(out_valid), 32'(tbl[k].e_ov));
      check($sformatf("tbl%0d_unexp", k), 32'(err_unexp), 32'(tbl[k].e_eun));
      if (tbl[k].e_ov) begin
        check($sformatf("tbl%0d_id", k), 32'(op_id_out), 32'(tbl[k].e_id));
        check($sformatf("tbl%0d_data", k), 32'(rd_data_out), 32'(tbl[k].e_dat));
        check($sformatf("tbl%0d_ch", k), 32'(ch_out), 32'(tbl[k].e_ch));
      end
    end

    // in-order tags and overflow on channel 0
    for (int j = 0; j < 4; j++) step(5'b00001, 8'h11 + 8'(j), '0, '0, 1'b1);
    check("full_busy0", 32'(sw_busy), 32'h1);
    step(5'b00001, 8'h15, '0, '0, 1'b1);
    check("ovf_pulse", 32'(err_ovf), 32'h1);
    idle(1'b1);
    check("ovf_clear", 32'(err_ovf), 32'h0);
    exp_q = {16'h11A0, 16'h12A1, 16'h13A2, 16'h14A3};
    for (int j = 0; j < 6; j++) begin
      logic [7:0] ad;
      ad = 8'hA0 + 8'(j);
      if (j < 4) step('0, 8'h00, 5'b00001, {N{ad}}, 1'b1);
      else       idle(1'b1);
      if (out_valid) begin
        if (exp_q.size() > 0) check("inorder_pair", {16'h0, op_id_out, rd_data_out}, 32'(exp_q.pop_front()));
        else                  check("inorder_extra", 32'(out_valid), 0);
      end
    end
    check("inorder_drained", exp_q.size(), 0);

    // contention on channels 0, 1, 4 from a fresh reset, two bursts
    do_reset();
    exp_ch = '{0, 1, 4};
    for (int b = 0; b < 2; b++) begin
      step(5'b10011, 8'hC0 + 8'(b), '0, '0, 1'b1);
      step('0, 8'h00, 5'b10011, {N{8'hD0 + 8'(b)}}, 1'b1);
      for (int k = 0; k < 3; k++) begin
        idle(1'b1);
        check($sformatf("cont%0d_valid%0d", b, k), 32'(out_valid), 1);
        check($sformatf("cont%0d_ch%0d", b, k), 32'(ch_out), 32'(exp_ch[k]));
      end
      idle(1'b1);
      check($sformatf("cont%0d_end", b), 32'(out_valid), 0);
    end

    // backpressure with a blocked hold on channel 2
    step(5'b00010, 8'h21, '0, '0, 1'b1);
    step(5'b00010, 8'h22, '0, '0, 1'b1);
    step(5'b00100, 8'h31, '0, '0, 1'b1);
    step(5'b00100, 8'h32, '0, '0, 1'b1);
    step('0, 8'h00, 5'b00110, 40'h00_00_42_41_00, 1'b0);
    for (int k = 0; k < 10; k++) begin
      idle(1'b0);
      check("bp_valid", 32'(out_valid), 1);
      check("bp_id", 32'(op_id_out), 32'h21);
      check("bp_data", 32'(rd_data_out), 32'h41);
      check("bp_ch", 32'(ch_out), 1);
    end
    step('0, 8'h00, 5'b00100, 40'h00_00_44_00_00, 1'b0);
    check("bp_unexp", 32'(err_unexp), 32'b00100);
    check("bp_hold_id", 32'(op_id_out), 32'h21);
    idle(1'b1);
    check("bp_next_id", 32'(op_id_out), 32'h31);
    check("bp_next_ch", 32'(ch_out), 2);
    idle(1'b1);
    check("bp_empty", 32'(out_valid), 0);

    // asynchronous reset mid-burst with three responses pending
    step(5'b00111, 8'h61, '0, '0, 1'b0);
    step('0, 8'h00, 5'b00111, 40'h00_00_72_71_70, 1'b0);
    idle(1'b0);
    check("pre_rst_valid", 32'(out_valid), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    sel_en = '0; ack = '0; rd_data = '0; out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all_zero("post_rst");
    step(5'b00001, 8'h99, '0, '0, 1'b1);
    step('0, 8'h00, 5'b00001, {N{8'hEE}}, 1'b1);
    idle(1'b1);
    check("fresh_valid", 32'(out_valid), 1);
    check("fresh_id", 32'(op_id_out), 32'h99);
    check("fresh_data", 32'(rd_data_out), 32'hEE);
    check("fresh_ch", 32'(ch_out), 0);

    // random traffic against the reference model
    for (int c = 0; c < 1500; c++) begin
      logic [N-1:0] s, a;
      for (int i = 0; i < N; i++) begin
        s[i] = ($urandom_range(0, 3) == 0);
        a[i] = ($urandom_range(0, 2) == 0);
      end
      step(s, 8'($urandom_range(0, 255)), a, {$urandom(), 8'($urandom_range(0, 255))},
           ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
